// File: rtl/shift_reg_pkg.sv
// Shared constants for the serial delay line.
package shift_reg_pkg;

    localparam int unsigned DEFAULT_LENGTH = 32;
    localparam logic        RST_VAL        = 1'b0;

endpackage

// File: rtl/shift_reg_stage.sv
// One delay-line stage: D flip-flop with asynchronous active-low clear.
module shift_stage
    import shift_reg_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = i_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/shift_reg_top.sv
// Serial-in/serial-out delay line of LENGTH stages; o_dout comes straight from the last flop.
module shift_reg_top
    import shift_reg_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_dout
);

    // chain[k] feeds stage k; chain[k+1] is its output
    logic [LENGTH:0] chain;

    assign chain[0] = i_din;

    genvar k;
    for (k = 0; k < int'(LENGTH); k++) begin : g_stage
        shift_stage u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (chain[k]),
            .o_q     (chain[k+1])
        );
    end

    assign o_dout = chain[LENGTH];

endmodule

// File: tb/tb_shift_reg_top.sv
// Directed and random bench for shift_reg_top at LENGTH = 32, 1 and 7, scoreboard-checked.
module tb_shift_reg_top;

    logic clk = 1'b0;
    logic rst_n;
    logic din;
    logic dout32;
    logic dout1;
    logic dout7;

    int n_checks = 0;
    int n_fail   = 0;

    logic q32[$];
    logic q1[$];
    logic q7[$];

    always #5 clk = ~clk;

    shift_reg_top #(.LENGTH(32)) u_dut32 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_din   (din),
        .o_dout  (dout32)
    );

    shift_reg_top #(.LENGTH(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_din   (din),
        .o_dout  (dout1)
    );

    shift_reg_top #(.LENGTH(7)) u_dut7 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_din   (din),
        .o_dout  (dout7)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // After reset the output reads LENGTH-1 zeros before the first new bit
    task automatic reset_model();
        q32.delete();
        q1.delete();
        q7.delete();
        for (int i = 0; i < 31; i++) q32.push_back(1'b0);
        for (int i = 0; i < 6; i++)  q7.push_back(1'b0);
    endtask

    task automatic step(input logic d, input string tag);
        logic e32, e1, e7;
        din = d;
        @(posedge clk);
        q32.push_back(d);
        q1.push_back(d);
        q7.push_back(d);
        #1;
        e32 = (q32.size() > 0) ? q32.pop_front() : 1'bx;
        e1  = (q1.size() > 0)  ? q1.pop_front()  : 1'bx;
        e7  = (q7.size() > 0)  ? q7.pop_front()  : 1'bx;
        check({tag, "_L32"}, dout32, e32);
        check({tag, "_L1"},  dout1,  e1);
        check({tag, "_L7"},  dout7,  e7);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_L32"}, dout32, 1'b0);
        check({tag, "_L1"},  dout1,  1'b0);
        check({tag, "_L7"},  dout7,  1'b0);
    endtask

    // Called just after a rising edge: low for half a clock, released before the next edge
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        reset_model();
        #1;
        check_all_zero(tag);
        #4;
        rst_n = 1'b1;
    endtask

    task automatic shift_word(input logic [31:0] w, input string tag);
        for (int i = 0; i < 32; i++) step(w[i], tag);
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, tag);
    endtask

    initial begin
        logic [31:0] w;

        // Reset held with din=1: outputs stay 0
        rst_n = 1'b0;
        din   = 1'b1;
        reset_model();
        #1;
        check_all_zero("rst_t0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Constant 1 after release: L32 rises on the 32nd edge
        for (int i = 0; i < 32; i++) step(1'b1, "ones_fill");
        check("ones_rise_L32", dout32, 1'b1);

        pulse_reset("rst_pre_word");
        shift_word(32'hDEADBEEF, "deadbeef");
        drain(32, "deadbeef_out");

        // Walking one
        pulse_reset("rst_pre_walk");
        step(1'b1, "walk");
        drain(40, "walk_zero");

        // Mid-operation reset discards a full register of ones
        shift_word(32'hFFFFFFFF, "ffff_load");
        check("ffff_loaded_L32", dout32, 1'b1);
        pulse_reset("rst_mid");
        drain(32, "rst_mid_zero");

        // Random words, each followed by a reset pulse
        for (int n = 0; n < 100; n++) begin
            w = $urandom();
            shift_word(w, "rand_in");
            drain(32, "rand_out");
            pulse_reset("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
